// File: rtl/periph_pkg.sv
// periph_pkg: shared defaults and types for the peripheral capture block
package periph_pkg;
    localparam int DATA_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT  = 8;
    localparam int DROP_CNT_W     = 8;
    typedef logic [15:0] periph_word_t;
endpackage

// File: rtl/periph_fifo.sv
// periph_fifo: synchronous FIFO holding captured words, with occupancy count
module periph_fifo
    import periph_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;

    // storage is not reset; only words below the level are ever observed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/periph_capture.sv
// periph_capture: captures CPU peripheral writes into a FIFO with drop accounting.
// Define PERIPH_CAPTURE_CHANGE_DETECT_EN to capture on data change instead of periph_we.
module periph_capture
    import periph_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      periph_data,
    input  logic                   periph_we,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_cnt,
    input  logic                   clr
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                  w_event;
    logic                  w_pop;
    logic                  w_drop;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

`ifdef PERIPH_CAPTURE_CHANGE_DETECT_EN
    logic [DATA_W-1:0] r_prev;
    logic              w_unused_we;

    assign w_unused_we = periph_we;
    assign w_event     = (periph_data != r_prev);

    // last sampled word, so a held value is captured only once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= '0;
        else        r_prev <= periph_data;
    end
`else
    assign w_event = periph_we;
`endif

    assign out_valid = (level != '0);
    assign w_pop     = out_valid & out_ready;
    assign w_drop    = w_event & (level == LW'(DEPTH)) & ~w_pop;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

    periph_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_event & ~w_drop),
        .i_pop   (w_pop),
        .i_data  (periph_data),
        .o_data  (out_data),
        .o_level (level)
    );

    // sticky overflow and saturating drop count; clr beats a same-edge drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_periph_capture.sv
// tb_periph_capture: randomized + directed checks of periph_capture against a queue model
module tb_periph_capture;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] periph_data = '0;
    logic        periph_we = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [15:0] q[$];
    logic        m_ovf = 1'b0;
    int          m_drop = 0;
    logic [15:0] m_prev = '0;

    periph_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .periph_data (periph_data),
        .periph_we   (periph_we),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .clr         (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_prev = '0;
    endtask

    // one clock: drive inputs, advance the model at the edge, return at the next negedge
    task automatic step(input logic we, input logic [15:0] d, input logic rdy, input logic c);
        logic ev;
        periph_we   = we;
        periph_data = d;
        out_ready   = rdy;
        clr         = c;
        @(posedge clk);
`ifdef PERIPH_CAPTURE_CHANGE_DETECT_EN
        ev = (d != m_prev);
        m_prev = d;
`else
        ev = we;
`endif
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (ev) begin
            if (q.size() < DEPTH) q.push_back(d);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (c) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        periph_we = 1'b0; periph_data = '0; out_ready = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
    endtask

    // continuous comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_level", level, q.size());
            chk("m_valid", out_valid, q.size() != 0);
            if (q.size() != 0) chk("m_data", out_data, q[0]);
            chk("m_ovf", overflow, m_ovf);
            chk("m_drop", drop_cnt, m_drop);
        end
    end

    initial begin
        do_reset();
`ifdef PERIPH_CAPTURE_CHANGE_DETECT_EN
        repeat (3) step(1'b1, 16'h0000, 1'b0, 1'b0);
        chk("cd_idle_level", level, 0);
        repeat (10) step(1'b0, 16'h0042, 1'b0, 1'b0);
        chk("cd_hold_level", level, 1);
        chk("cd_first", out_data, 16'h0042);
        step(1'b0, 16'h0043, 1'b0, 1'b0);
        chk("cd_two_level", level, 2);
        step(1'b1, 16'h0043, 1'b1, 1'b0);
        chk("cd_second", out_data, 16'h0043);
        chk("cd_after_pop", level, 1);
        step(1'b0, 16'h0043, 1'b1, 1'b0);
        chk("cd_empty", out_valid, 0);
        for (int i = 0; i < 1200; i++)
            step(1'b0, 16'($urandom_range(0, 3)), $urandom_range(0, 3) < (i < 600 ? 1 : 3), $urandom_range(0, 31) == 0);
`else
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("pp_valid", out_valid, 1);
        chk("pp_data", out_data, 16'h1234);
        chk("pp_level", level, 1);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("pp_level0", level, 0);
        chk("pp_valid0", out_valid, 0);

        for (int i = 1; i <= 9; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("ov_level", level, 8);
        chk("ov_flag", overflow, 1);
        chk("ov_drop", drop_cnt, 1);
        for (int i = 1; i <= 8; i++) begin
            chk("ov_order", out_data, i);
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        chk("ov_drained", level, 0);

        step(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
        step(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("fp_level", level, 8);
        chk("fp_drop", drop_cnt, 0);
        chk("fp_ovf", overflow, 0);
        for (int i = 2; i <= 8; i++) begin
            chk("fp_order", out_data, 16'h10 + i);
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        chk("fp_last", out_data, 16'h00AA);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        repeat (300) step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_ovf", overflow, 1);
        step(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_level", level, 8);
        repeat (8) step(1'b0, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 1200; i++)
            step($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) < (i < 600 ? 1 : 3), $urandom_range(0, 31) == 0);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h50 + i), 1'b0, 1'b0);
        chk("mr_level5", level, 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_level", level, 0);
        chk("mr_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("mr_stay", level, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/periph_capture.md
PERIPH_CAPTURE -- requirements
Module: periph_capture

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the peripheral word width.
REQ-002 Parameter DEPTH, default 8, power of two >= 2, SHALL set the capture FIFO depth.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous assert, active-low, synchronous deassert by the integrator.
REQ-005 Port periph_data, input, DATA_W, SHALL carry the CPU PeripheralBuffer word.
REQ-006 Port periph_we, input, 1, SHALL be the CPU peripheral write strobe (ignored when PERIPH_CAPTURE_CHANGE_DETECT_EN is defined).
REQ-007 Port out_data, output, DATA_W, SHALL be the oldest captured word.
REQ-008 Port out_valid, output, 1, SHALL indicate that out_data holds a valid word.
REQ-009 Port out_ready, input, 1, SHALL indicate that the consumer accepts out_data this cycle.
REQ-010 Port level, output, $clog2(DEPTH)+1, SHALL report the FIFO occupancy.
REQ-011 Port overflow, output, 1, SHALL be a sticky flag indicating that a capture was dropped.
REQ-012 Port drop_cnt, output, 8, SHALL count dropped captures, saturating at 255.
REQ-013 Port clr, input, 1, SHALL synchronously clear overflow and drop_cnt without touching FIFO contents.

Function
REQ-014 A capture event SHALL be periph_we=1 sampled on a clk edge; the word captured SHALL be periph_data at that edge.
REQ-015 A pop SHALL occur when out_valid=1 and out_ready=1 at the same edge.
REQ-016 On a capture with level<DEPTH, the word SHALL be written at the tail; with no simultaneous pop, level SHALL increment by 1.
REQ-017 On a capture with level==DEPTH and no pop at that edge, the word SHALL be dropped, overflow SHALL set, and drop_cnt SHALL increment (saturating).
REQ-018 On a capture and a pop at the same edge with level==DEPTH, the capture SHALL be accepted and level SHALL stay DEPTH.
REQ-019 On a capture and a pop at the same edge with level==0 is impossible because out_valid=0; the capture SHALL be accepted normally.
REQ-020 out_valid SHALL equal (level!=0), registered; capture-to-out_valid latency SHALL be exactly 1 cycle, with no combinational bypass from periph_data to out_data.
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH.
REQ-023 When clr and a drop occur at the same edge, clr SHALL win: overflow=0 and drop_cnt=0.

Reset
REQ-024 While rst_n=0: level=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0, and pointers=0; FIFO storage need not be cleared.
REQ-025 Reset asserted mid-operation SHALL discard all buffered words immediately (asynchronously).

Configuration
REQ-026 With PERIPH_CAPTURE_CHANGE_DETECT_EN defined:
  - A prev register (reset value 0) SHALL track periph_data every cycle.
  - A capture event SHALL be periph_data != prev, and periph_we SHALL be ignored.
  - A constant nonzero value after reset SHALL therefore be captured exactly once.
REQ-027 Without PERIPH_CAPTURE_CHANGE_DETECT_EN, the prev register SHALL NOT exist, and capture SHALL follow REQ-014 only.

Structure
REQ-028 Package periph_pkg SHALL hold DATA_W_DEFAULT=16, DEPTH_DEFAULT=8, DROP_CNT_W=8, and typedef periph_word_t (logic [15:0]).
REQ-029 Storage and pointers SHALL live in one sub-module, periph_fifo (synchronous FIFO with push/pop/level); periph_capture SHALL own event detection, overflow, and drop_cnt.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Push/pop: reset, pulse periph_we with data 0x1234, out_ready=0 -> next cycle out_valid=1, out_data=0x1234, level=1; then out_ready=1 -> level=0, out_valid=0.
  - Overflow: 9 strobes 0x0001..0x0009 with out_ready=0 (DEPTH=8) -> level=8, overflow=1, drop_cnt=1; drain order 0x0001..0x0008.
  - Full with simultaneous push/pop: level=8, out_ready=1, and a strobe with 0x00AA on the same edge -> level stays 8, no drop, 0x00AA is last out.
  - Saturation and clr: 300 drops -> drop_cnt=255; clr pulse -> overflow=0, drop_cnt=0, level unchanged.
  - Reset mid-stream: assert rst_n=0 with level=5 -> out_valid=0 and level=0 immediately, without waiting for a clk edge.
  - Change-detect build (macro defined): periph_data held at 0x0000, then 0x0042 for 10 cycles, then 0x0042->0x0043 -> exactly two captures, 0x0042 then 0x0043.
